// File: rtl/mux_scan_pkg.sv
// Shared definitions for the multiplexer scan controller: FSM states,
// channel/select geometry and the dwell counter width.
package mux_scan_pkg;

   localparam int CH_N          = 4;
   localparam int SEL_W         = 2;
   localparam int DWELL_DEFAULT = 4;
   localparam int CNT_W         = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } scan_state_e;

   // Value loaded into the dwell counter at the start of each channel window.
   function automatic logic [CNT_W-1:0] dwell_reload(input int dwell);
      return CNT_W'(dwell - 1);
   endfunction

endpackage

// File: rtl/scan_dwell_cnt.sv
// Loadable down-counter that measures how long each select value is held.
// Saturates at zero; the controller always reloads before it would wrap.
module scan_dwell_cnt
   import mux_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 4->1 multiplexer select through all channels, dwelling on each,
// and publishes the captured 4-bit snapshot with a done/changed pulse.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int DWELL = DWELL_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   input  logic             abort,
   input  logic             z_in,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             done,
   output logic [CH_N-1:0]  sample,
   output logic             changed
);

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CH_N - 1);
   localparam logic [CNT_W-1:0] RELOAD   = dwell_reload(DWELL);

   scan_state_e      state_q,   state_d;
   logic [SEL_W-1:0] sel_q,     sel_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic             changed_q, changed_d;
   logic [CH_N-1:0]  sample_q,  sample_d;
   logic [CH_N-2:0]  shadow_q,  shadow_d;
   logic [CH_N-1:0]  new_sample;

   logic cnt_load;
   logic cnt_dec;
   logic cnt_zero;

   scan_dwell_cnt u_dwell_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (RELOAD),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      done_d     = 1'b0;
      changed_d  = 1'b0;
      sample_d   = sample_q;
      shadow_d   = shadow_q;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      new_sample = {z_in, shadow_q};

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d  = SETTLE;
               sel_d    = '0;
               cnt_load = 1'b1;
            end
         end

         SETTLE: begin
            if (abort) begin
               state_d  = IDLE;
               sel_d    = '0;
               shadow_d = '0;
            end else if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else if (sel_q != LAST_SEL) begin
               shadow_d[sel_q] = z_in;
               sel_d           = sel_q + 1'b1;
               cnt_load        = 1'b1;
            end else begin
               // Last channel: z_in completes the snapshot directly.
               state_d   = DONE;
               sample_d  = new_sample;
               changed_d = (new_sample != sample_q);
               done_d    = 1'b1;
               sel_d     = '0;
               shadow_d  = '0;
            end
         end

         DONE: begin
            sel_d = '0;
            if (abort) begin
               state_d = IDLE;
            end else if (cont) begin
               state_d  = SETTLE;
               cnt_load = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d  = IDLE;
            sel_d    = '0;
            shadow_d = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         changed_q <= 1'b0;
         sample_q  <= '0;
         shadow_q  <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         changed_q <= changed_d;
         sample_q  <= sample_d;
         shadow_q  <= shadow_d;
      end
   end

   assign sel     = sel_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign changed = changed_q;
   assign sample  = sample_q;

endmodule
